// File: rtl/cond_wb_stage.sv
// ---------------------------------------------------------------------------
// cond_wb_stage
//   Conditional-execution stage between the ALU and writeback. It holds the
//   architectural flag register, decides whether each incoming instruction
//   executes by testing its condition field against the current flags, gates
//   the write/branch controls accordingly, and registers the result for the
//   downstream stage behind a one-entry valid/ready pipeline register.
//   Squashed instructions are still forwarded, so transaction order is kept.
//
// Optional feature:
//   COND_SQUASH_CNT_EN  when defined, SquashCount counts squashed accepts
//                       and saturates at 16'hFFFF; otherwise it reads zero.
//
// Ports
//   clk         clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   in_valid    upstream transaction valid
//   in_ready    stage can accept this cycle (combinational)
//   ALUResult   ALU result
//   ALUFlags    ALU flags {C,Z,N,V}
//   Cond        condition field
//   FlagW       [1] updates N,Z ; [0] updates C,V
//   RegW/MemW/PCS  unconditional control requests
//   Rd          destination register
//   out_valid   registered transaction available
//   out_ready   downstream accepts the registered transaction
//   Result_q/Rd_q  registered result and destination
//   RegWrite/MemWrite/PCSrc  condition-gated controls (registered)
//   Flags       architectural flags {C,Z,N,V}
//   SquashCount squashed-transaction counter
// ---------------------------------------------------------------------------
module cond_wb_stage #(
  parameter int RD_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      ALUResult,
  input  logic [3:0]      ALUFlags,
  input  logic [3:0]      Cond,
  input  logic [1:0]      FlagW,
  input  logic            RegW,
  input  logic            MemW,
  input  logic            PCS,
  input  logic [RD_W-1:0] Rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      Result_q,
  output logic [RD_W-1:0] Rd_q,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            PCSrc,
  output logic [3:0]      Flags,
  output logic [15:0]     SquashCount
);

  // Flag bit positions inside the {C,Z,N,V} vector.
  localparam int FC = 3;
  localparam int FZ = 2;
  localparam int FN = 1;
  localparam int FV = 0;

  // Condition evaluation against a flag vector {C,Z,N,V}.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
    logic c, z, n, v, res;
    c = f[FC];
    z = f[FZ];
    n = f[FN];
    v = f[FV];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;  // 1111 never executes
    endcase
    return res;
  endfunction

  logic            out_valid_r;
  logic [7:0]      result_r;
  logic [RD_W-1:0] rd_r;
  logic            regwrite_r;
  logic            memwrite_r;
  logic            pcsrc_r;
  logic [3:0]      flags_r;

  logic            accept_s;
  logic            cond_ex_s;
  logic [3:0]      flags_nxt_s;

  // Handshake and condition decode; condition uses pre-update flags.
  always_comb begin
    in_ready  = ~out_valid_r | out_ready;
    accept_s  = in_valid & in_ready;
    cond_ex_s = cond_check(Cond, flags_r);
  end

  // Next flag value: only an executed, accepted instruction may write flags.
  always_comb begin
    flags_nxt_s = flags_r;
    if (accept_s && cond_ex_s) begin
      if (FlagW[1]) begin
        flags_nxt_s[FZ] = ALUFlags[FZ];
        flags_nxt_s[FN] = ALUFlags[FN];
      end else begin
        flags_nxt_s[FZ] = flags_r[FZ];
        flags_nxt_s[FN] = flags_r[FN];
      end
      if (FlagW[0]) begin
        flags_nxt_s[FC] = ALUFlags[FC];
        flags_nxt_s[FV] = ALUFlags[FV];
      end else begin
        flags_nxt_s[FC] = flags_r[FC];
        flags_nxt_s[FV] = flags_r[FV];
      end
    end else begin
      flags_nxt_s = flags_r;
    end
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  // Output pipeline register: load on accept, clear valid when drained empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      result_r    <= 8'h00;
      rd_r        <= '0;
      regwrite_r  <= 1'b0;
      memwrite_r  <= 1'b0;
      pcsrc_r     <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      result_r    <= ALUResult;
      rd_r        <= Rd;
      regwrite_r  <= RegW & cond_ex_s;
      memwrite_r  <= MemW & cond_ex_s;
      pcsrc_r     <= PCS & cond_ex_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef COND_SQUASH_CNT_EN
  logic [15:0] squash_cnt_r;

  // Saturating count of accepted-but-squashed instructions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash_cnt_r <= 16'h0000;
    end else if (accept_s && !cond_ex_s && (squash_cnt_r != 16'hFFFF)) begin
      squash_cnt_r <= squash_cnt_r + 16'h0001;
    end
  end

  assign SquashCount = squash_cnt_r;
`else
  assign SquashCount = 16'h0000;
`endif

  assign out_valid = out_valid_r;
  assign Result_q  = result_r;
  assign Rd_q      = rd_r;
  assign RegWrite  = regwrite_r;
  assign MemWrite  = memwrite_r;
  assign PCSrc     = pcsrc_r;
  assign Flags     = flags_r;

endmodule

// File: tb/tb_cond_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_cond_wb_stage
//   Directed self-checking bench for cond_wb_stage. Inputs change and outputs
//   are sampled 1 time unit after the rising edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_cond_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ALUResult;
  logic [3:0]  ALUFlags;
  logic [3:0]  Cond;
  logic [1:0]  FlagW;
  logic        RegW, MemW, PCS;
  logic [3:0]  Rd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Result_q;
  logic [3:0]  Rd_q;
  logic        RegWrite, MemWrite, PCSrc;
  logic [3:0]  Flags;
  logic [15:0] SquashCount;

  int checks_cnt;
  int errors_cnt;

  cond_wb_stage #(.RD_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .ALUFlags(ALUFlags), .Cond(Cond), .FlagW(FlagW),
    .RegW(RegW), .MemW(MemW), .PCS(PCS), .Rd(Rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result_q(Result_q), .Rd_q(Rd_q),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc),
    .Flags(Flags), .SquashCount(SquashCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] res, input logic [3:0] af,
                       input logic [3:0] cd, input logic [1:0] fw,
                       input logic rw, input logic mw, input logic ps, input logic [3:0] rd);
    in_valid  = v;
    ALUResult = res;
    ALUFlags  = af;
    Cond      = cd;
    FlagW     = fw;
    RegW      = rw;
    MemW      = mw;
    PCS       = ps;
    Rd        = rd;
  endtask

  logic [15:0] exp_sq;

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    exp_sq     = 16'h0000;
    reset      = 1'b0;
    out_ready  = 1'b1;
    drive(1'b0, 8'h00, 4'b0000, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
    #23;
    check_val("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check_val("rst_flags", {12'd0, Flags}, 16'h0000);
    check_val("rst_result", {8'd0, Result_q}, 16'h0000);
    check_val("rst_rd", {12'd0, Rd_q}, 16'h0000);
    check_val("rst_ctrl", {13'd0, RegWrite, MemWrite, PCSrc}, 16'h0000);
    check_val("rst_squash", SquashCount, 16'h0000);
    check_val("rst_in_ready", {15'd0, in_ready}, 16'h0001);
    reset = 1'b1;
    step();

    // AL with FlagW=11 loads Z
    drive(1'b1, 8'h00, 4'b0100, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h3);
    step();
    check_val("al_flags", {12'd0, Flags}, 16'h0004);
    check_val("al_out_valid", {15'd0, out_valid}, 16'h0001);
    check_val("al_rd", {12'd0, Rd_q}, 16'h0003);

    // EQ with Z=1 executes
    drive(1'b1, 8'h5A, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 4'h1);
    step();
    check_val("eq_regwrite", {15'd0, RegWrite}, 16'h0001);
    check_val("eq_result", {8'd0, Result_q}, 16'h005A);
    check_val("eq_flags_hold", {12'd0, Flags}, 16'h0004);

    // clear flags
    drive(1'b1, 8'h01, 4'b0000, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h2);
    step();
    check_val("clr_flags", {12'd0, Flags}, 16'h0000);

    // EQ with Z=0 squashes; flags must not change despite FlagW
    drive(1'b1, 8'h33, 4'b1111, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b0, 4'h4);
    step();
`ifdef COND_SQUASH_CNT_EN
    exp_sq = exp_sq + 16'h0001;
`endif
    check_val("sq_ctrl", {13'd0, RegWrite, MemWrite, PCSrc}, 16'h0000);
    check_val("sq_flags", {12'd0, Flags}, 16'h0000);
    check_val("sq_fwd_valid", {15'd0, out_valid}, 16'h0001);
    check_val("sq_fwd_result", {8'd0, Result_q}, 16'h0033);
    check_val("sq_count1", SquashCount, exp_sq);

    // set V=1 only
    drive(1'b1, 8'h02, 4'b0001, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    check_val("v_flags", {12'd0, Flags}, 16'h0001);

    // LT with N!=V executes
    drive(1'b1, 8'h03, 4'b0000, 4'b1011, 2'b00, 1'b0, 1'b0, 1'b1, 4'h0);
    step();
    check_val("lt_pcsrc", {15'd0, PCSrc}, 16'h0001);

    // GE squashes
    drive(1'b1, 8'h04, 4'b0000, 4'b1010, 2'b00, 1'b0, 1'b0, 1'b1, 4'h0);
    step();
`ifdef COND_SQUASH_CNT_EN
    exp_sq = exp_sq + 16'h0001;
`endif
    check_val("ge_pcsrc", {15'd0, PCSrc}, 16'h0000);

    // LE with N!=V executes
    drive(1'b1, 8'h77, 4'b0000, 4'b1101, 2'b00, 1'b1, 1'b0, 1'b0, 4'h5);
    step();
    check_val("le_regwrite", {15'd0, RegWrite}, 16'h0001);

    // 1111 never executes
    drive(1'b1, 8'h99, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 4'h6);
    step();
`ifdef COND_SQUASH_CNT_EN
    exp_sq = exp_sq + 16'h0001;
`endif
    check_val("nv_ctrl", {13'd0, RegWrite, MemWrite, PCSrc}, 16'h0000);
    check_val("nv_flags", {12'd0, Flags}, 16'h0001);
    check_val("sq_count3", SquashCount, exp_sq);

    // backpressure: hold for 3 cycles
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 4'b1000, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'h7);
    #1;
    check_val("bp_in_ready", {15'd0, in_ready}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_result_hold", {8'd0, Result_q}, 16'h0099);
      check_val("bp_rd_hold", {12'd0, Rd_q}, 16'h0006);
      check_val("bp_flags_hold", {12'd0, Flags}, 16'h0001);
      check_val("bp_valid_hold", {15'd0, out_valid}, 16'h0001);
    end

    // release: drain and accept in the same cycle
    out_ready = 1'b1;
    #1;
    check_val("rel_in_ready", {15'd0, in_ready}, 16'h0001);
    step();
    check_val("rel_result", {8'd0, Result_q}, 16'h00AA);
    check_val("rel_flags", {12'd0, Flags}, 16'h0008);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 4'b0000, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'(i));
      step();
      check_val("b2b_valid", {15'd0, out_valid}, 16'h0001);
      check_val("b2b_result", {8'd0, Result_q}, 16'h0010 + 16'(i));
      check_val("b2b_rd", {12'd0, Rd_q}, 16'(i));
    end

    // drain with no new input
    drive(1'b0, 8'h00, 4'b0000, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    check_val("drain_valid", {15'd0, out_valid}, 16'h0000);

    // reset while holding a stalled transaction
    drive(1'b1, 8'hC3, 4'b0110, 4'b1110, 2'b11, 1'b1, 1'b0, 1'b0, 4'h9);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    check_val("pre_rst_valid", {15'd0, out_valid}, 16'h0001);
    check_val("pre_rst_flags", {12'd0, Flags}, 16'h0006);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst_valid", {15'd0, out_valid}, 16'h0000);
    check_val("async_rst_flags", {12'd0, Flags}, 16'h0000);
    check_val("async_rst_result", {8'd0, Result_q}, 16'h0000);
    check_val("async_rst_squash", SquashCount, 16'h0000);
    exp_sq = 16'h0000;
    #3;
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h42, 4'b0000, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'h1);
    step();
    check_val("post_rst_accept", {15'd0, out_valid}, 16'h0001);
    check_val("post_rst_result", {8'd0, Result_q}, 16'h0042);

    // squash counter saturation / tie-off
    drive(1'b1, 8'h00, 4'b0000, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0);
`ifdef COND_SQUASH_CNT_EN
    repeat (65535) @(posedge clk);
    #1;
    check_val("sat_reach", SquashCount, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    check_val("sat_hold", SquashCount, 16'hFFFF);
`else
    repeat (5) @(posedge clk);
    #1;
    check_val("squash_tied", SquashCount, 16'h0000);
`endif
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
